noc_input_buffer: RTL and testbench

- Per-direction input stage of the 5-port router. One instance each for L, N, E, W and S.
- Buffers incoming flits in a FIFO and tracks packet framing (header/body/tail).
- Drives the arbiter-facing request, flit_id and length signals consumed by the arbiter and its timeout timers.
- On grant, forwards flits to the crossbar until the tail flit leaves.

---
 rtl/noc_input_buffer.sv | 190 +++++++++++++++++++
 tb/tb_noc_input_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_input_buffer.sv
// noc_fifo: generic first-word-fall-through FIFO with occupancy count.
// Latency: a pushed word is visible at rd_dat the cycle after the push; pop is same-cycle.
// Backpressure: wr_rdy drops when full; rd_rdy is ignored while empty.
//
// Ports: clk/rst (sync, active-high), wr_vld/wr_rdy/wr_dat write side,
//        rd_vld/rd_rdy/rd_dat read side (head shown combinationally), count occupancy.
module noc_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic [PTR_W:0]   count
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign wr_rdy  = (count != FULL_CNT);
    assign rd_vld  = (count != '0);
    assign do_push = wr_vld && wr_rdy;
    assign do_pop  = rd_rdy && rd_vld;
    assign rd_dat  = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; stale entries are never visible because count gates rd_vld.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= wr_dat;
    end
endmodule

// noc_input_buffer: per-direction router input stage, flit FIFO plus packet framing FSM.
// Latency: a flit is at the head one cycle after push; req rises one cycle after a header reaches the head.
// Backpressure: in_ready = !full; head pops only on grant && out_ready, stalls otherwise.
//
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_flit_id/in_data upstream;
//        grant/req/arb_flit_id/arb_length arbiter side; out_valid/out_ready/out_flit_id/out_data
//        crossbar side; count occupancy; err one-cycle framing-error pulse.
module noc_input_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [2:0]        in_flit_id,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              grant,
    input  logic              out_ready,
    output logic              req,
    output logic [2:0]        arb_flit_id,
    output logic [11:0]       arb_length,
    output logic              out_valid,
    output logic [2:0]        out_flit_id,
    output logic [DATA_W-1:0] out_data,
    output logic [PTR_W:0]    count,
    output logic              err
);
    localparam logic [2:0] FLIT_HDR  = 3'b001;
    localparam logic [2:0] FLIT_TAIL = 3'b100;

    typedef struct packed {
        logic [2:0]        flit_id;
        logic [DATA_W-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    flit_t       wr_flit;
    flit_t       head;
    logic        head_vld;
    logic        pop;
    logic        err_set;
    logic        len_load;
    logic [11:0] len_reg;
    logic        head_is_hdr;
    logic        head_is_tail;

    assign wr_flit = '{flit_id: in_flit_id, data: in_data};

    noc_fifo #(
        .WIDTH ($bits(flit_t)),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (in_valid),
        .wr_rdy (in_ready),
        .wr_dat (wr_flit),
        .rd_vld (head_vld),
        .rd_rdy (pop),
        .rd_dat (head),
        .count  (count)
    );

    assign head_is_hdr  = head_vld && (head.flit_id == FLIT_HDR);
    assign head_is_tail = head_vld && (head.flit_id == FLIT_TAIL);

    assign out_flit_id = head.flit_id;
    assign out_data    = head.data;
    assign arb_flit_id = head_vld ? head.flit_id : 3'b000;
    assign arb_length  = head_is_hdr ? head.data[11:0] : len_reg;
    assign req         = (state != ST_IDLE);
    assign out_valid   = head_vld && grant && (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            len_reg <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= err_set;
            if (len_load) len_reg <= head.data[11:0];
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        err_set   = 1'b0;
        len_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (head_is_hdr) begin
                    state_nxt = ST_REQ;
                    len_load  = 1'b1;
                end else if (head_vld) begin
                    // Orphan body/tail with no open packet: drop it.
                    pop     = 1'b1;
                    err_set = 1'b1;
                end
            end
            ST_REQ: begin
                if (grant && out_ready && head_vld) begin
                    pop       = 1'b1;
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (head_is_hdr) begin
                    // Previous packet lost its tail; restart arbitration for the new one.
                    err_set   = 1'b1;
                    len_load  = 1'b1;
                    state_nxt = ST_REQ;
                end else if (grant && out_ready && head_vld) begin
                    pop = 1'b1;
                    if (head_is_tail) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_noc_input_buffer.sv
module tb_noc_input_buffer;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;
    localparam logic [2:0] H = 3'b001;
    localparam logic [2:0] B = 3'b010;
    localparam logic [2:0] T = 3'b100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [2:0]        in_flit_id = 3'b000;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              grant = 1'b0;
    logic              out_ready = 1'b0;
    logic              req;
    logic [2:0]        arb_flit_id;
    logic [11:0]       arb_length;
    logic              out_valid;
    logic [2:0]        out_flit_id;
    logic [DATA_W-1:0] out_data;
    logic [PTR_W:0]    count;
    logic              err;

    noc_input_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_flit_id  (in_flit_id),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .grant       (grant),
        .out_ready   (out_ready),
        .req         (req),
        .arb_flit_id (arb_flit_id),
        .arb_length  (arb_length),
        .out_valid   (out_valid),
        .out_flit_id (out_flit_id),
        .out_data    (out_data),
        .count       (count),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Flits still to be offered upstream, and the reference FIFO contents.
    logic [34:0] tx_q[$];
    logic [34:0] mq[$];
    bit          gaps = 1'b0;

    // Reference packet view: open = a header has been taken as the current packet,
    // sent = that header has already left toward the crossbar.
    bit          m_open = 1'b0;
    bit          m_sent = 1'b0;
    bit          m_err  = 1'b0;
    bit          m_ok   = 1'b0;
    logic [11:0] m_len  = '0;
    int          fwd_cnt = 0;
    int          err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [34:0] mk(input logic [2:0] id, input logic [11:0] len);
        logic [19:0] hi;
        hi = 20'($urandom);
        return {id, hi, len};
    endfunction

    task automatic send_pkt(input logic [11:0] len, input int nbody, input bit with_tail);
        tx_q.push_back(mk(H, len));
        for (int i = 0; i < nbody; i++) tx_q.push_back(mk(B, 12'($urandom)));
        if (with_tail) tx_q.push_back(mk(T, 12'($urandom)));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((tx_q.size() != 0 || mq.size() != 0 || m_open) && n < budget) begin
            cyc(1);
            n++;
        end
        chk(name, (tx_q.size() == 0 && mq.size() == 0 && !m_open), 1);
    endtask

    // Upstream driver: holds a flit until it is accepted, optional idle gaps.
    initial begin
        bit acc;
        forever begin
            @(negedge clk);
            acc = in_valid && in_ready && !rst;
            @(posedge clk);
            #1;
            if (acc && tx_q.size() > 0) void'(tx_q.pop_front());
            if (tx_q.size() > 0 && !rst &&
                ((in_valid && !acc) || !gaps || $urandom_range(0, 3) != 0)) begin
                in_valid   = 1'b1;
                in_flit_id = tx_q[0][34:32];
                in_data    = tx_q[0][31:0];
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    // Monitor: compares DUT outputs with the reference each cycle, then advances the reference.
    initial begin
        logic [34:0] front;
        bit          ne, fh, pop, nerr;
        int          sz0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
                m_open = 0; m_sent = 0; m_len = '0; m_err = 0; m_ok = 1;
            end else if (m_ok) begin
                sz0   = mq.size();
                ne    = (sz0 != 0);
                front = ne ? mq[0] : '0;
                fh    = ne && (front[34:32] == H);
                chk("count", 32'(count), 32'(sz0));
                chk("in_ready", 32'(in_ready), 32'(sz0 < DEPTH));
                chk("req", 32'(req), 32'(m_open));
                chk("out_valid", 32'(out_valid), 32'(ne && grant && m_open));
                chk("err", 32'(err), 32'(m_err));
                chk("arb_flit_id", 32'(arb_flit_id), 32'(ne ? front[34:32] : 3'b000));
                chk("arb_length", 32'(arb_length), 32'(fh ? front[11:0] : m_len));
                if (out_valid && out_ready) begin
                    chk("out_flit_id", 32'(out_flit_id), 32'(front[34:32]));
                    chk("out_data", out_data, front[31:0]);
                end
                pop = 0; nerr = 0;
                if (!m_open) begin
                    if (fh) begin
                        m_open = 1; m_len = front[11:0];
                    end else if (ne) begin
                        pop = 1; nerr = 1;
                    end
                end else if (!m_sent) begin
                    if (grant && out_ready) begin
                        pop = 1; m_sent = 1; fwd_cnt++;
                    end
                end else if (ne) begin
                    if (fh) begin
                        nerr = 1; m_sent = 0; m_len = front[11:0];
                    end else if (grant && out_ready) begin
                        pop = 1; fwd_cnt++;
                        if (front[34:32] == T) begin
                            m_open = 0; m_sent = 0;
                        end
                    end
                end
                if (pop) void'(mq.pop_front());
                if (in_valid && sz0 < DEPTH) mq.push_back({in_flit_id, in_data});
                if (nerr) err_cnt++;
                m_err = nerr;
            end
        end
    end

    initial begin
        int base;
        int n;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("reset_count", 32'(count), 0);
        chk("reset_req", 32'(req), 0);
        chk("reset_in_ready", 32'(in_ready), 1);

        // Basic packet: header(len=5), two bodies, tail.
        grant = 1; out_ready = 1;
        send_pkt(12'd5, 2, 1);
        wait_idle("basic_pkt_done", 100);

        // Fill with grant low, ninth flit must be held off.
        grant = 0;
        send_pkt(12'd7, 7, 1);
        cyc(15);
        chk("fill_count", 32'(count), DEPTH);
        chk("fill_in_ready", 32'(in_ready), 0);
        chk("fill_pending", tx_q.size(), 1);
        grant = 1;
        wait_idle("fill_drain", 100);

        // Grant withdrawn for 3 cycles after the first body leaves.
        base = fwd_cnt;
        send_pkt(12'd4, 3, 1);
        n = 0;
        while (fwd_cnt < base + 2 && n < 50) begin cyc(1); n++; end
        chk("stall_reach", 32'(fwd_cnt >= base + 2), 1);
        grant = 0;
        repeat (3) begin
            cyc(1);
            chk("stall_req", 32'(req), 1);
            chk("stall_out_valid", 32'(out_valid), 0);
        end
        grant = 1;
        wait_idle("stall_resume", 100);

        // Orphan body in idle: discarded with an error pulse.
        base = err_cnt;
        tx_q.push_back(mk(B, 12'h0ab));
        wait_idle("orphan_drop", 50);
        cyc(2);
        chk("orphan_err_cnt", err_cnt, base + 1);

        // Missing tail: second header restarts arbitration.
        base = err_cnt;
        send_pkt(12'd3, 1, 0);
        send_pkt(12'd9, 1, 1);
        wait_idle("missing_tail", 100);
        chk("missing_tail_err_cnt", err_cnt, base + 1);

        // Reset mid-packet with four flits buffered.
        grant = 0;
        send_pkt(12'd6, 3, 0);
        n = 0;
        while ((mq.size() != 4 || tx_q.size() != 0) && n < 50) begin cyc(1); n++; end
        chk("pre_reset_count", 32'(count), 4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("post_reset_count", 32'(count), 0);
        chk("post_reset_req", 32'(req), 0);
        chk("post_reset_out_valid", 32'(out_valid), 0);
        chk("post_reset_err", 32'(err), 0);
        grant = 1;
        send_pkt(12'd2, 1, 1);
        wait_idle("post_reset_pkt", 100);

        // Randomised traffic with random grant/out_ready and occasional framing faults.
        gaps = 1'b1;
        for (int p = 0; p < 20; p++) begin
            if ($urandom_range(0, 7) == 0) tx_q.push_back(mk(B, 12'($urandom)));
            send_pkt(12'($urandom), $urandom_range(0, 4), $urandom_range(0, 7) != 0);
        end
        send_pkt(12'd1, 0, 1);
        n = 0;
        while (tx_q.size() != 0 && n < 2000) begin
            grant     = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
            n++;
        end
        grant = 1; out_ready = 1;
        wait_idle("random_drain", 500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
